// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests,
// buffers responses in a 2-entry queue and presents one instruction per cycle to Decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        dec_valid,
    output logic [31:0] dec_instruction,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_pc_plus4
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] fetch_pc_reg;
    logic [1:0]  out_cnt_reg;
    logic [1:0]  drop_cnt_reg;
    logic [1:0]  occ_reg;
    logic        head_reg;
    logic        tail_reg;
    logic        rpc_head_reg;
    logic        rpc_tail_reg;

    logic [31:0] slot_instr [2];
    logic [31:0] slot_pc    [2];
    logic [31:0] slot_rpc   [2];

    logic        pop;
    logic        credit;
    logic        accept;
    logic        rsp_fire;
    logic        push;
    logic [2:0]  inflight;
    logic [31:0] rsp_pc;
    logic        unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign dec_valid      = ~rst & ~redirect_valid & (occ_reg != 2'd0);
    assign pop            = dec_valid & ~stall;
    // Requests in flight plus buffered entries may never exceed the queue depth.
    assign inflight       = {1'b0, out_cnt_reg} + {1'b0, occ_reg};
    assign credit         = inflight < (3'd2 + {2'b00, pop});
    assign imem_req_valid = ~rst & ~redirect_valid & credit;
    assign imem_req_addr  = fetch_pc_reg;
    assign accept         = imem_req_valid & imem_req_ready;
    assign rsp_fire       = imem_rsp_valid & (out_cnt_reg != 2'd0);
    assign push           = rsp_fire & ~redirect_valid & (drop_cnt_reg == 2'd0);
    assign rsp_pc         = slot_rpc[rpc_head_reg];

    assign dec_instruction = dec_valid ? slot_instr[head_reg] : NOP;
    assign dec_pc          = dec_valid ? slot_pc[head_reg] : 32'd0;
    assign dec_pc_plus4    = dec_valid ? slot_pc[head_reg] + 32'd4 : 32'd0;

    // Storage slots carry no reset: occupancy and pointers define validity.
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        logic [31:0] instr_reg;
        logic [31:0] pc_reg;
        logic [31:0] rpc_reg;

        always_ff @(posedge clk) begin
            if (push && tail_reg == 1'(gi)) begin
                instr_reg <= imem_rsp_data;
                pc_reg    <= rsp_pc;
            end
            if (accept && rpc_tail_reg == 1'(gi)) begin
                rpc_reg <= fetch_pc_reg;
            end
        end

        assign slot_instr[gi] = instr_reg;
        assign slot_pc[gi]    = pc_reg;
        assign slot_rpc[gi]   = rpc_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg <= RESET_PC;
            out_cnt_reg  <= 2'd0;
            drop_cnt_reg <= 2'd0;
            occ_reg      <= 2'd0;
            head_reg     <= 1'b0;
            tail_reg     <= 1'b0;
            rpc_head_reg <= 1'b0;
            rpc_tail_reg <= 1'b0;
        end else begin
            case ({accept, rsp_fire})
                2'b10:   out_cnt_reg <= out_cnt_reg + 2'd1;
                2'b01:   out_cnt_reg <= out_cnt_reg - 2'd1;
                default: out_cnt_reg <= out_cnt_reg;
            endcase
            if (accept) begin
                rpc_tail_reg <= ~rpc_tail_reg;
            end
            if (rsp_fire) begin
                rpc_head_reg <= ~rpc_head_reg;
            end

            if (redirect_valid) begin
                // Every request still pending after this edge belongs to the old path.
                fetch_pc_reg <= {redirect_pc[31:2], 2'b00};
                drop_cnt_reg <= out_cnt_reg - {1'b0, rsp_fire};
                occ_reg      <= 2'd0;
                head_reg     <= 1'b0;
                tail_reg     <= 1'b0;
            end else begin
                if (accept) begin
                    fetch_pc_reg <= fetch_pc_reg + 32'd4;
                end
                if (rsp_fire && drop_cnt_reg != 2'd0) begin
                    drop_cnt_reg <= drop_cnt_reg - 2'd1;
                end
                if (push) begin
                    tail_reg <= ~tail_reg;
                end
                if (pop) begin
                    head_reg <= ~head_reg;
                end
                occ_reg <= occ_reg + {1'b0, push} - {1'b0, pop};
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: in-order memory model, expected-instruction
// scoreboard filled at request acceptance, scenario table plus directed corner cases.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        dec_valid;
    logic [31:0] dec_instruction;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc_plus4;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .dec_valid       (dec_valid),
        .dec_instruction (dec_instruction),
        .dec_pc          (dec_pc),
        .dec_pc_plus4    (dec_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        int          lat;
        bit          rand_rdy;
        int          stall_pct;
        int          redir_every;
        logic [31:0] redir_base;
        int          cycles;
        int          min_dec;
    } scen_t;

    mreq_t       mq[$];
    exp_t        sb[$];
    int          cyc;
    int          lat;
    int          n_vec;
    int          n_bad;
    int          dec_count;
    logic [31:0] exp_fetch_pc;

    bit          watch_dec;
    bit          watch_req;
    logic [31:0] seen_dec_pc;
    logic [31:0] seen_req_addr;
    bit          wrap_seen;
    logic [31:0] wrap_plus4;

    logic        last_dec_valid;
    logic [31:0] last_dec_pc;
    logic [31:0] last_dec_plus4;
    logic [31:0] last_dec_instr;
    logic        last_req_valid;
    logic [31:0] last_req_addr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return ~a ^ 32'h1234_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle; entered and left just after a falling edge.
    task automatic cycle();
        imem_rsp_valid = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_data  = imem_rsp_valid ? mq[0].data : 32'hDEAD_BEEF;
        #1;
        last_dec_valid = dec_valid;
        last_dec_pc    = dec_pc;
        last_dec_plus4 = dec_pc_plus4;
        last_dec_instr = dec_instruction;
        last_req_valid = imem_req_valid;
        last_req_addr  = imem_req_addr;

        if (rst) begin
            check1("rst_req_valid", imem_req_valid, 1'b0);
            check1("rst_dec_valid", dec_valid, 1'b0);
            check("rst_dec_instr", dec_instruction, 32'h0000_0013);
            check("rst_dec_pc", dec_pc, 32'd0);
            check("rst_dec_pc_plus4", dec_pc_plus4, 32'd0);
        end else begin
            if (redirect_valid) begin
                check1("redir_dec_valid", dec_valid, 1'b0);
                check1("redir_req_valid", imem_req_valid, 1'b0);
            end
            if (dec_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL dec_unexpected: got pc %h, expected no instruction (cycle %0d)", dec_pc, cyc);
                end else begin
                    check("dec_pc", dec_pc, sb[0].pc);
                    check("dec_instr", dec_instruction, sb[0].instr);
                    check("dec_pc_plus4", dec_pc_plus4, sb[0].pc + 32'd4);
                    if (!stall) begin
                        $display("dec  cyc=%0d pc=%h instr=%h", cyc, dec_pc, dec_instruction);
                        void'(sb.pop_front());
                        dec_count++;
                    end
                end
                if (watch_dec) begin
                    seen_dec_pc = dec_pc;
                    watch_dec   = 1'b0;
                end
                if (dec_pc == 32'hFFFF_FFFC) begin
                    wrap_seen  = 1'b1;
                    wrap_plus4 = dec_pc_plus4;
                end
            end else begin
                check("bubble_instr", dec_instruction, 32'h0000_0013);
                check("bubble_pc", dec_pc, 32'd0);
                check("bubble_pc_plus4", dec_pc_plus4, 32'd0);
            end
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, exp_fetch_pc);
                if (watch_req) begin
                    seen_req_addr = imem_req_addr;
                    watch_req     = 1'b0;
                end
                mq.push_back('{data: instr_of(imem_req_addr), due: cyc + lat});
                sb.push_back('{pc: exp_fetch_pc, instr: instr_of(exp_fetch_pc)});
                exp_fetch_pc += 32'd4;
            end
        end

        if (imem_rsp_valid) void'(mq.pop_front());
        check1("outstanding_le2", mq.size() <= 2, 1'b1);

        if (rst) begin
            mq.delete();
            sb.delete();
            exp_fetch_pc = RESET_PC;
        end else if (redirect_valid) begin
            sb.delete();
            exp_fetch_pc = {redirect_pc[31:2], 2'b00};
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_req_ready = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        cyc = 0;
    endtask

    scen_t vec[5];

    initial begin
        n_vec = 0; n_bad = 0; cyc = 0; lat = 1; dec_count = 0;
        exp_fetch_pc = RESET_PC;
        watch_dec = 1'b0; watch_req = 1'b0; wrap_seen = 1'b0;
        seen_dec_pc = 32'd0; seen_req_addr = 32'd0; wrap_plus4 = 32'hFFFF_FFFF;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;

        vec[0] = '{lat: 1, rand_rdy: 0, stall_pct: 0,  redir_every: 0,  redir_base: 32'h0,         cycles: 200, min_dec: 198};
        vec[1] = '{lat: 2, rand_rdy: 0, stall_pct: 0,  redir_every: 0,  redir_base: 32'h0,         cycles: 200, min_dec: 50};
        vec[2] = '{lat: 3, rand_rdy: 1, stall_pct: 30, redir_every: 0,  redir_base: 32'h0,         cycles: 300, min_dec: 30};
        vec[3] = '{lat: 1, rand_rdy: 1, stall_pct: 20, redir_every: 13, redir_base: 32'h0000_1000, cycles: 300, min_dec: 30};
        vec[4] = '{lat: 3, rand_rdy: 0, stall_pct: 10, redir_every: 17, redir_base: 32'h8000_0000, cycles: 300, min_dec: 20};

        @(negedge clk);

        // Scenario table: each entry starts with a reset taken mid-operation.
        for (int s = 0; s < 5; s++) begin
            lat = vec[s].lat;
            do_reset();
            dec_count = 0;
            for (int c = 0; c < vec[s].cycles; c++) begin
                stall          = ($urandom_range(0, 99) < vec[s].stall_pct);
                imem_req_ready = vec[s].rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                redirect_valid = (vec[s].redir_every > 0) && (c % vec[s].redir_every == vec[s].redir_every - 1);
                redirect_pc    = vec[s].redir_base + 32'(c << 4) + 32'(c & 3);
                cycle();
            end
            redirect_valid = 1'b0;
            stall          = 1'b0;
            imem_req_ready = 1'b1;
            check1("scen_throughput", dec_count >= vec[s].min_dec, 1'b1);
        end

        // Latency 1, no stall: first request to RESET_PC, Decode busy from cycle 2.
        lat = 1;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (c == 0) begin
                check1("first_req_valid", last_req_valid, 1'b1);
                check("first_req_addr", last_req_addr, RESET_PC);
            end
            if (c >= 2) begin
                check1("stream_dec_valid", last_dec_valid, 1'b1);
                check("stream_dec_pc", last_dec_pc, 32'(4 * (c - 2)));
                check("stream_dec_pc_plus4", last_dec_plus4, 32'(4 * (c - 1)));
            end
        end

        // Stall for 5 cycles with PC 8 at Decode, then release.
        do_reset();
        repeat (4) cycle();
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("stall_hold_pc", last_dec_pc, 32'h8);
            check1("stall_hold_valid", last_dec_valid, 1'b1);
            if (k >= 1) check1("stall_no_req", last_req_valid, 1'b0);
        end
        stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("release_order", last_dec_pc, 32'(8 + 4 * k));
        end

        // Redirect with two requests in flight at latency 3.
        lat = 3;
        do_reset();
        repeat (6) cycle();
        check("inflight_before_redir", 32'(mq.size()), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        cycle();
        redirect_valid = 1'b0;
        watch_dec      = 1'b1;
        repeat (15) cycle();
        check1("redir_dec_seen", watch_dec, 1'b0);
        check("redir_first_dec_pc", seen_dec_pc, 32'h0000_0100);

        // Misaligned redirect landing on a response cycle.
        lat = 1;
        do_reset();
        repeat (4) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        watch_req      = 1'b1;
        watch_dec      = 1'b1;
        cycle();
        redirect_valid = 1'b0;
        repeat (6) cycle();
        check("redir_rsp_req_addr", seen_req_addr, 32'h0000_0200);
        check("redir_rsp_dec_pc", seen_dec_pc, 32'h0000_0200);

        // Fetch PC wrap at the top of the address space.
        do_reset();
        repeat (2) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        cycle();
        redirect_valid = 1'b0;
        wrap_seen      = 1'b0;
        repeat (8) cycle();
        check1("wrap_seen", wrap_seen, 1'b1);
        check("wrap_pc_plus4", wrap_plus4, 32'h0);

        // Reset with the queue full.
        do_reset();
        repeat (4) cycle();
        stall = 1'b1;
        repeat (3) cycle();
        stall = 1'b0;
        rst   = 1'b1;
        cycle();
        rst       = 1'b0;
        watch_req = 1'b1;
        cycle();
        check1("post_rst_dec_valid", last_dec_valid, 1'b0);
        check("post_rst_dec_instr", last_dec_instr, 32'h0000_0013);
        check("post_rst_req_addr", seen_req_addr, RESET_PC);
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
